// File: rtl/lc3_memory_ctrl.sv
// LC-3 memory subsystem: MAR/MDR, synchronous RAM and a wait-state access FSM.
// Define LC3_MEM_VIEW_EN to add the front-panel debug/view port on the array.
module lc3_memory_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              Load_MAR,
  input  logic              Load_MDR,
  input  logic              Mem_EN,
  input  logic              Mem_WE,
  output logic [DATA_W-1:0] Memory_Out,
  output logic              Mem_R,
  output logic              Busy
`ifdef LC3_MEM_VIEW_EN
  ,
  input  logic              View_WE,
  input  logic [ADDR_W-1:0] View_Address,
  input  logic [DATA_W-1:0] View_Data,
  output logic [DATA_W-1:0] View_Out
`endif
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_W-1:0]       mar_q, mar_d;
  logic [DATA_W-1:0]       mdr_q, mdr_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    op_we_q, op_we_d;
  logic                    core_we;
  logic                    rd_commit;
  logic                    core_we_eff;

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_we_d   = op_we_q;
    mar_d     = Load_MAR ? Bus_In[ADDR_W-1:0] : mar_q;
    mdr_d     = Load_MDR ? Bus_In : mdr_q;
    core_we   = 1'b0;
    rd_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Operands come from the current registers, so same-cycle loads
        // only affect the next access.
        if (Mem_EN) begin
          addr_d  = mar_q[DEPTH_LOG2-1:0];
          wdata_d = mdr_q;
          op_we_d = Mem_WE;
          count_d = CNT_W'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          core_we   = op_we_q;
          rd_commit = ~op_we_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset landing on the commit edge must suppress the write.
  assign core_we_eff = core_we & ~Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mar_q   <= mar_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_we_q <= op_we_d;
      // Read completion takes priority over a concurrent Load_MDR.
      mdr_q   <= rd_commit ? mem_q[addr_q] : mdr_d;
    end
  end

`ifdef LC3_MEM_VIEW_EN
  logic [DEPTH_LOG2-1:0] view_idx;
  logic [DATA_W-1:0]     view_out_q;

  assign view_idx = View_Address[DEPTH_LOG2-1:0];

  always_ff @(posedge Clk) begin
    if (View_WE && !(core_we_eff && (view_idx == addr_q))) begin
      mem_q[view_idx] <= View_Data;
    end
    if (core_we_eff) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      view_out_q <= '0;
    end else begin
      view_out_q <= mem_q[view_idx];
    end
  end

  assign View_Out = view_out_q;
`else
  always_ff @(posedge Clk) begin
    if (core_we_eff) begin
      mem_q[addr_q] <= wdata_q;
    end
  end
`endif

  assign Memory_Out = mdr_q;
  assign Mem_R      = (state_q == S_DONE);
  assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lc3_memory_ctrl.sv
// Bench for lc3_memory_ctrl: three instances (default, 256-word W=2, 256-word W=0)
// checked cycle by cycle, with read data matched through a scoreboard queue.
module tb_lc3_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] bus_in   [3];
  logic        load_mar [3];
  logic        load_mdr [3];
  logic        mem_en   [3];
  logic        mem_we   [3];
  logic [15:0] mem_out  [3];
  logic        mem_r    [3];
  logic        busy     [3];
`ifdef LC3_MEM_VIEW_EN
  logic        view_we   [3];
  logic [15:0] view_addr [3];
  logic [15:0] view_data [3];
  logic [15:0] view_out  [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      lc3_memory_ctrl #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .DEPTH_LOG2 ((gi == 0) ? 16 : 8),
        .WAIT_STATES((gi == 2) ? 0 : 2)
      ) u_dut (
        .Clk         (clk),
        .Reset       (rst),
        .Bus_In      (bus_in[gi]),
        .Load_MAR    (load_mar[gi]),
        .Load_MDR    (load_mdr[gi]),
        .Mem_EN      (mem_en[gi]),
        .Mem_WE      (mem_we[gi]),
        .Memory_Out  (mem_out[gi]),
        .Mem_R       (mem_r[gi]),
        .Busy        (busy[gi])
`ifdef LC3_MEM_VIEW_EN
        ,
        .View_WE     (view_we[gi]),
        .View_Address(view_addr[gi]),
        .View_Data   (view_data[gi]),
        .View_Out    (view_out[gi])
`endif
      );
    end
  endgenerate

  function automatic int ws(input int k);
    return (k == 2) ? 0 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mar(input int k, input logic [15:0] v);
    @(posedge clk); #1;
    load_mar[k] = 1'b1;
    bus_in[k]   = v;
    @(posedge clk); #1;
    load_mar[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_mdr(input int k, input logic [15:0] v);
    @(posedge clk); #1;
    load_mdr[k] = 1'b1;
    bus_in[k]   = v;
    @(posedge clk); #1;
    load_mdr[k] = 1'b0;
    @(negedge clk);
  endtask

  // mode: 0 plain, 1 mid-access MAR/MDR loads, 2 Load_MDR on read commit,
  //       3 reset in 2nd ACCESS cycle, 4 Load_MAR with request, 5 view write on commit
  task automatic do_access(input int k, input bit we, input int mode,
                           input logic [15:0] aux, input logic [15:0] exp_rd);
    int  w;
    bit  exp_busy;
    bit  exp_r;
    w = ws(k);
    if (!we) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    mem_en[k] = 1'b1;
    mem_we[k] = we;
    if (mode == 4) begin
      load_mar[k] = 1'b1;
      bus_in[k]   = aux;
    end
    for (int c = 1; c <= w + 3; c++) begin
      @(posedge clk); #1;
      mem_en[k]   = 1'b0;
      load_mar[k] = 1'b0;
      load_mdr[k] = 1'b0;
      rst         = 1'b0;
`ifdef LC3_MEM_VIEW_EN
      view_we[k]  = 1'b0;
`endif
      case (mode)
        1: begin
          if (c == 1) begin load_mar[k] = 1'b1; bus_in[k] = 16'h4000; end
          if (c == 2) begin load_mdr[k] = 1'b1; bus_in[k] = aux; end
        end
        2: if (c == w + 1) begin load_mdr[k] = 1'b1; bus_in[k] = aux; end
        3: if (c == 2) rst = 1'b1;
`ifdef LC3_MEM_VIEW_EN
        5: if (c == w + 1) begin
          view_we[k]   = 1'b1;
          view_addr[k] = 16'h0020;
          view_data[k] = aux;
        end
`endif
        default: ;
      endcase
      @(negedge clk);
      exp_busy = (c <= w + 2) && !(mode == 3 && c >= 3);
      exp_r    = (c == w + 2) && (mode != 3);
      check_eq("busy", busy[k], exp_busy);
      check_eq("mem_r", mem_r[k], exp_r);
      if (mem_r[k] && !we) begin
        if (exp_q.size() > 0) check_eq("rd_data", mem_out[k], exp_q.pop_front());
        else check_eq("sb_extra", exp_q.size(), 1);
      end
`ifdef LC3_MEM_VIEW_EN
      if (mode == 5 && c == w + 3) check_eq("view_collide", view_out[k], 16'h9999);
`endif
    end
    $display("access dut%0d we=%0d mode=%0d aux=0x%0h mdr=0x%0h", k, we, mode, aux, mem_out[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_in[k] = '0; load_mar[k] = 0; load_mdr[k] = 0; mem_en[k] = 0; mem_we[k] = 0;
`ifdef LC3_MEM_VIEW_EN
      view_we[k] = 0; view_addr[k] = '0; view_data[k] = '0;
`endif
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_eq("rst_mdr", mem_out[k], 16'h0000);
        check_eq("rst_mem_r", mem_r[k], 1'b0);
        check_eq("rst_busy", busy[k], 1'b0);
      end
    end
`ifdef LC3_MEM_VIEW_EN
    check_eq("rst_view", view_out[0], 16'h0000);
`endif

    // Known background values
    set_mar(0, 16'h4000); set_mdr(0, 16'h7777); do_access(0, 1, 0, 0, 0);
    set_mar(0, 16'h3001); set_mdr(0, 16'h0123); do_access(0, 1, 0, 0, 0);

    // Basic write then read
    set_mar(0, 16'h3000); set_mdr(0, 16'hBEEF); do_access(0, 1, 0, 0, 0);
    set_mdr(0, 16'h0000); do_access(0, 0, 0, 0, 16'hBEEF);

    // Mid-access loads do not disturb the in-flight write
    set_mdr(0, 16'hC0DE);
    do_access(0, 1, 1, 16'h1111, 0);
    check_eq("mid_mdr", mem_out[0], 16'h1111);
    do_access(0, 0, 0, 0, 16'h7777);
    set_mar(0, 16'h3000);
    do_access(0, 0, 0, 0, 16'hC0DE);

    // Read completion beats a concurrent Load_MDR
    do_access(0, 0, 2, 16'hFFFF, 16'hC0DE);
    check_eq("collide_mdr", mem_out[0], 16'hC0DE);

    // Load_MAR with the request: old MAR used, new MAR next
    set_mar(0, 16'h4000);
    do_access(0, 0, 4, 16'h3000, 16'h7777);
    do_access(0, 0, 0, 0, 16'hC0DE);

    // Reset during ACCESS aborts the write
    set_mar(0, 16'h3001); set_mdr(0, 16'hAAAA);
    do_access(0, 1, 3, 0, 0);
    check_eq("abort_mdr", mem_out[0], 16'h0000);
    set_mar(0, 16'h3001);
    do_access(0, 0, 0, 0, 16'h0123);

    // Address wrap on a 256-word array, W=2 and W=0
    set_mar(1, 16'h0105); set_mdr(1, 16'h5555); do_access(1, 1, 0, 0, 0);
    set_mar(1, 16'h0005); set_mdr(1, 16'h0000); do_access(1, 0, 0, 0, 16'h5555);
    set_mar(2, 16'h0105); set_mdr(2, 16'h6A6A); do_access(2, 1, 0, 0, 0);
    set_mar(2, 16'h0005); set_mdr(2, 16'h0000); do_access(2, 0, 0, 0, 16'h6A6A);

`ifdef LC3_MEM_VIEW_EN
    // Core write beats a view write to the same address
    set_mar(0, 16'h0020); set_mdr(0, 16'h9999);
    do_access(0, 1, 5, 16'h1234, 0);
    // Standalone view write, seen by a core read
    @(posedge clk); #1;
    view_we[0] = 1'b1; view_addr[0] = 16'h0044; view_data[0] = 16'hABCD;
    @(posedge clk); #1;
    view_we[0] = 1'b0;
    set_mar(0, 16'h0044);
    do_access(0, 0, 0, 0, 16'hABCD);
`endif

    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
